bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 106 ++++++++++
 tb/tb_bin2bcd_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3).
// Accepts unsigned (0..255) or two's complement (-128..127) input.
// Converts the magnitude in 8 shift cycles and reports the sign separately.
// The digit and sign outputs only change on the cycle that done pulses.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sgn_mode,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic       neg,
  output logic [3:0] d_hun,
  output logic [3:0] d_ten,
  output logic [3:0] d_one
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [11:0] scratch;
  logic [11:0] scratch_adj;
  logic [11:0] scratch_shl;
  logic [7:0]  mag;
  logic [2:0]  cnt;
  logic        neg_int;
  logic        last;

  // A nibble of 5 or more would pass 9 after doubling, so pre-correct it by 3.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Absolute value of din; -128 (8'h80) maps to 128, which still fits in 8 bits.
  function automatic logic [7:0] magnitude(input logic s, input logic [7:0] d);
    return (s & d[7]) ? (~d + 8'd1) : d;
  endfunction

  // Correction, shift and last-iteration detection for the current SHIFT edge.
  always_comb begin
    scratch_adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
    scratch_shl = {scratch_adj[10:0], mag[7]};
    last        = (state == SHIFT) && (cnt == 3'd7);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start launches a conversion, eight shifts end it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; results are written only on the final shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch <= 12'd0;
      mag     <= 8'd0;
      cnt     <= 3'd0;
      neg_int <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      neg     <= 1'b0;
      d_hun   <= 4'd0;
      d_ten   <= 4'd0;
      d_one   <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag     <= magnitude(sgn_mode, din);
            neg_int <= sgn_mode & din[7];
            scratch <= 12'd0;
            cnt     <= 3'd0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= scratch_shl;
          mag     <= {mag[6:0], 1'b0};
          cnt     <= cnt + 3'd1;
          if (last) begin
            d_hun <= scratch_shl[11:8];
            d_ten <= scratch_shl[7:4];
            d_one <= scratch_shl[3:0];
            neg   <= neg_int;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: cycle-level reference model with per-cycle compare,
// plus directed conversions checked against hand-computed digits.
module tb_bin2bcd_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sgn_mode;
  logic [7:0] din;
  logic       busy, done, neg;
  logic [3:0] d_hun, d_ten, d_one;

  int tests = 0;
  int fails = 0;

  bin2bcd_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sgn_mode(sgn_mode), .din(din),
    .busy(busy), .done(done), .neg(neg),
    .d_hun(d_hun), .d_ten(d_ten), .d_one(d_one)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a conversion is a countdown of 8 cycles, the result is
  // plain decimal arithmetic on the magnitude.
  int         m_cnt;
  logic       m_busy, m_done, m_neg, p_neg;
  logic [3:0] m_h, m_t, m_o;
  int         p_mag;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_neg <= 1'b0;
      m_h <= 4'd0; m_t <= 4'd0; m_o <= 4'd0; p_neg <= 1'b0; p_mag <= 0;
    end else if (m_cnt == 0) begin
      m_done <= 1'b0;
      if (start) begin
        p_neg  <= sgn_mode & din[7];
        p_mag  <= (sgn_mode & din[7]) ? 256 - int'(din) : int'(din);
        m_cnt  <= 8;
        m_busy <= 1'b1;
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_busy <= 1'b0;
        m_neg  <= p_neg;
        m_h    <= 4'(p_mag / 100);
        m_t    <= 4'((p_mag / 10) % 10);
        m_o    <= 4'(p_mag % 10);
      end else begin
        m_done <= 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("cmp busy", busy, m_busy);
    check("cmp done", done, m_done);
    check("cmp neg", neg, m_neg);
    check("cmp d_hun", d_hun, m_h);
    check("cmp d_ten", d_ten, m_t);
    check("cmp d_one", d_one, m_o);
  end

  task automatic convert(input logic s, input logic [7:0] d, input logic en,
                         input logic [3:0] eh, input logic [3:0] et,
                         input logic [3:0] eo, input string nm);
    int j;
    @(negedge clk);
    sgn_mode = s; din = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    din = 8'($urandom_range(255, 0));
    sgn_mode = 1'($urandom_range(1, 0));
    j = 1;
    while (!done && j < 20) begin
      @(negedge clk);
      j++;
    end
    check({nm, " latency"}, j - 1, 8);
    check({nm, " neg"}, neg, en);
    check({nm, " hun"}, d_hun, eh);
    check({nm, " ten"}, d_ten, et);
    check({nm, " one"}, d_one, eo);
  endtask

  task automatic wait_idle();
    int j;
    j = 0;
    while ((busy || done) && j < 20) begin
      @(negedge clk);
      j++;
    end
    check("wait idle bound", (busy || done), 0);
  endtask

  initial begin
    int ndone;
    int pos[$];
    int mag;
    start = 1'b0; sgn_mode = 1'b0; din = 8'd0; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset digits", {neg, d_hun, d_ten, d_one}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Unsigned maximum, and pin the model itself to literals.
    convert(1'b0, 8'd255, 1'b0, 4'd2, 4'd5, 4'd5, "u255");
    check("model pin hun", m_h, 2);
    check("model pin ten", m_t, 5);
    check("model pin one", m_o, 5);

    // Signed boundaries.
    convert(1'b1, 8'h80, 1'b1, 4'd1, 4'd2, 4'd8, "s-128");
    check("model pin neg", m_neg, 1);
    convert(1'b1, 8'h7F, 1'b0, 4'd1, 4'd2, 4'd7, "s127");
    convert(1'b1, 8'hFF, 1'b1, 4'd0, 4'd0, 4'd1, "s-1");
    convert(1'b1, 8'h00, 1'b0, 4'd0, 4'd0, 4'd0, "s0");

    // Second start during busy is ignored.
    @(negedge clk);
    sgn_mode = 1'b0; din = 8'd42; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); din = 8'd99; start = 1'b1;
    @(negedge clk); start = 1'b0; din = 8'd0;
    ndone = 0;
    for (int i = 4; i < 24; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("ign latency", i + 1, 9);
        check("ign result", {neg, d_hun, d_ten, d_one}, {1'b0, 4'd0, 4'd4, 4'd2});
      end
    end
    check("ign done count", ndone, 1);

    // start held high: back-to-back conversions every 9 cycles.
    @(negedge clk);
    sgn_mode = 1'b0; din = 8'd7; start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        pos.push_back(i);
        check("held result", {neg, d_hun, d_ten, d_one}, {1'b0, 4'd0, 4'd0, 4'd7});
      end
    end
    start = 1'b0;
    check("held pulse count", pos.size(), 4);
    check("held first", (pos.size() > 0) ? pos[0] : 0, 9);
    for (int i = 1; i < pos.size(); i++) check("held spacing", pos[i] - pos[i-1], 9);
    wait_idle();

    // Reset mid-conversion aborts with no done pulse.
    convert(1'b0, 8'd200, 1'b0, 4'd2, 4'd0, 4'd0, "u200");
    @(negedge clk);
    sgn_mode = 1'b0; din = 8'd13; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort outputs", {neg, d_hun, d_ten, d_one}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no done", ndone, 0);

    // start accepted on the first edge after reset release.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; sgn_mode = 1'b0; din = 8'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first edge busy", busy, 1);
    wait_idle();
    check("first edge result", {neg, d_hun, d_ten, d_one}, {1'b0, 4'd0, 4'd1, 4'd3});

    // Exhaustive sweep in both modes.
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 256; v++) begin
        mag = (s == 1 && v >= 128) ? 256 - v : v;
        convert(1'(s), 8'(v), 1'(s == 1 && v >= 128),
                4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10),
                $sformatf("sweep m%0d v%0d", s, v));
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
